timer_array: RTL and testbench
==============================

// Module: timer_array
// PURPOSE
// - Parametrised multi-channel down-counting timer on the CPU system bus (CLK_I/ADD_I/WE_I/DAT_I/DAT_O).
// - Each channel: CTRL, PRESET, COUNT, STAT registers; one-shot or auto-reload mode; per-channel W1C pending flag.
// - Per-channel IRQ vector plus OR-combined IRQ to the CP0 interrupt input.
// PARAMETERS
// - N_CH   4   number of channels, 1..16
// - CNT_W  32  COUNT/PRESET width, 1..32; DAT_I bits above CNT_W ignored, read back as 0
// PORTS
// - CLK_I  in   1      system clock, all state on rising edge
// - RST_I  in   1      asynchronous, active-high reset
// - ADD_I  in   [7:2]  ADD_I[7:4] channel index, ADD_I[3:2] register select
// - WE_I   in   1      write strobe, single-cycle, sampled at CLK_I rising edge
// - DAT_I  in   32     write data
// - DAT_O  out  32     read data, combinational from ADD_I
// - IRQ_V  out  N_CH   per-channel interrupt = STAT.P & CTRL.IM
// - IRQ    out  1      OR of IRQ_V
// BEHAVIOUR
// - Register select: 0 CTRL, 1 PRESET, 2 COUNT (read-only, writes ignored), 3 STAT.
// - CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved = hold, no decrement, no pending), [3] IM.
// - STAT: [0] P pending; write 1 clears, write 0 no effect.
// - Channel index >= N_CH: reads 0, writes ignored.
// - Reset: all CTRL/PRESET/COUNT/STAT = 0, prescaler state = 0; DAT_O follows ADD_I; IRQ_V = 0, IRQ = 0.
// - Write to CTRL taking EN 0->1 loads COUNT <= PRESET on the same edge (no decrement that edge).
// - Per channel, when EN=1 and a tick occurs and no EN 0->1 load happens that edge:
//   - COUNT != 0: COUNT <= COUNT-1.
//   - COUNT == 0, mode 00: P <= 1, EN <= 0, COUNT stays 0.
//   - COUNT == 0, mode 01: P <= 1, COUNT <= PRESET (value before any same-edge PRESET write).
// - Latency: enable at edge k with PRESET=Pv -> P set at edge k+Pv+1 (tick every cycle); reload period Pv+1 ticks.
// - PRESET=0 in mode 01: P set every tick.
// - Simultaneous events: expiry and STAT clear on same edge -> P stays 1 (set wins).
// - Expiry and CTRL write on same edge -> CTRL takes written value, except one-shot expiry
//   forces EN=0 unless the write itself is an EN 0->1 load. P still set.
// - Writing EN=0 freezes COUNT; P unchanged. Writing EN=1 while EN already 1 does not reload.
// - PRESET write does not affect a running COUNT until next load/reload.
// - Writes are channel-local; one write per cycle.
// - Mid-operation RST_I: immediate clear of all state, IRQ deasserts asynchronously.
// - IRQ_V/IRQ registered-state derived (combinational from P and IM); clearing IM masks without clearing P.
// CONFIGURATION
// - TIMER_PRESCALE_EN defined: CTRL[15:8] = PSC (R/W). Per-channel 8-bit prescale counter;
//   tick when prescale counter == PSC, then counter <= 0; counter cleared on EN 0->1 and while EN=0.
//   PSC=0 -> tick every cycle; PSC=n -> one tick per n+1 cycles.
// - TIMER_PRESCALE_EN undefined: tick every cycle; CTRL[15:8] writes ignored, read as 0; no prescale state.
// - CTRL[31:16] (and [15:4] without macro): read as 0, writes ignored.
// TESTING
// - Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at edge k -> COUNT 5..0, IRQ_V[0]/IRQ high after edge k+6, CTRL.EN reads 0.
// - Ch2 PRESET=3, CTRL=0xB (reload) -> P set every 4 cycles; STAT write 1 clears; clear on expiry edge leaves P=1.
// - Ch1 PRESET=2 with IM=0 -> P=1 but IRQ=0; then set IM -> IRQ rises; write 0 to STAT -> still pending.
// - Write ADD_I channel 5 with N_CH=4 -> no state change, reads 0; write COUNT reg -> ignored.
// - Assert RST_I mid-count on ch3 -> all regs 0, IRQ low immediately, no tick after release until re-enabled.
// - TIMER_PRESCALE_EN, PSC=2, PRESET=1, one-shot -> P set 6 cycles after enable; without macro CTRL[15:8] reads 0.

Source files
------------

// File: rtl/timer_array.sv
// timer_array: multi-channel down-counting timer on the CPU system bus.
// Each channel has CTRL, PRESET, COUNT and STAT registers, one-shot or
// auto-reload operation, a write-one-to-clear pending flag and a maskable IRQ.
// Optional feature macro: TIMER_PRESCALE_EN adds an 8-bit per-channel
// prescaler programmed through CTRL[15:8].
module timer_array #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [7:2]        ADD_I,
  input  logic              WE_I,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  output logic [N_CH-1:0]   IRQ_V,
  output logic              IRQ
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Registered channel state
  logic [N_CH-1:0]  en_q, im_q, pend_q;
  logic [1:0]       mode_q   [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
`ifdef TIMER_PRESCALE_EN
  logic [7:0]       psc_q    [N_CH];
  logic [7:0]       pcnt_q   [N_CH];
`endif

  // Next-state values
  logic [N_CH-1:0]  en_d, im_d, pend_d;
  logic [1:0]       mode_d   [N_CH];
  logic [CNT_W-1:0] preset_d [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
`ifdef TIMER_PRESCALE_EN
  logic [7:0]       psc_d    [N_CH];
  logic [7:0]       pcnt_d   [N_CH];
`endif

  // Per-channel event strobes
  logic [N_CH-1:0]  wr_ctrl, wr_pre, wr_stat;
  logic [N_CH-1:0]  load, tick, act, expire;

  // Decode bus writes, derive tick/expiry events and compute next state
  always_comb begin
    en_d    = en_q;
    im_d    = im_q;
    pend_d  = pend_q;
    wr_ctrl = '0;
    wr_pre  = '0;
    wr_stat = '0;
    load    = '0;
    tick    = '0;
    act     = '0;
    expire  = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]   = mode_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
`ifdef TIMER_PRESCALE_EN
      psc_d[i]    = psc_q[i];
      pcnt_d[i]   = pcnt_q[i];
`endif

      wr_ctrl[i] = WE_I && (ADD_I[7:4] == 4'(i)) && (ADD_I[3:2] == REG_CTRL);
      wr_pre[i]  = WE_I && (ADD_I[7:4] == 4'(i)) && (ADD_I[3:2] == REG_PRESET);
      wr_stat[i] = WE_I && (ADD_I[7:4] == 4'(i)) && (ADD_I[3:2] == REG_STAT);

      // Only an EN 0->1 transition loads; rewriting EN=1 keeps counting.
      load[i] = wr_ctrl[i] && DAT_I[0] && !en_q[i];

`ifdef TIMER_PRESCALE_EN
      tick[i] = (pcnt_q[i] == psc_q[i]);
`else
      tick[i] = 1'b1;
`endif

      // Reserved modes (MODE[1]=1) hold the counter and never expire.
      act[i]    = en_q[i] && tick[i] && !mode_q[i][1] && !load[i];
      expire[i] = act[i] && (count_q[i] == '0);

      if (wr_ctrl[i]) begin
        en_d[i]   = DAT_I[0];
        mode_d[i] = DAT_I[2:1];
        im_d[i]   = DAT_I[3];
`ifdef TIMER_PRESCALE_EN
        psc_d[i]  = DAT_I[15:8];
`endif
      end

      // One-shot expiry wins over a same-edge CTRL write (a load cannot
      // coincide with expiry since expiry needs EN already set).
      if (expire[i] && (mode_q[i] == MODE_ONESHOT))
        en_d[i] = 1'b0;

      if (wr_pre[i])
        preset_d[i] = DAT_I[CNT_W-1:0];

      // Reload uses the PRESET value held before any same-edge write.
      if (load[i])
        count_d[i] = preset_q[i];
      else if (act[i]) begin
        if (count_q[i] != '0)
          count_d[i] = count_q[i] - CNT_W'(1);
        else if (mode_q[i] == MODE_RELOAD)
          count_d[i] = preset_q[i];
      end

      // Setting the pending flag takes priority over a W1C clear.
      if (expire[i])
        pend_d[i] = 1'b1;
      else if (wr_stat[i] && DAT_I[0])
        pend_d[i] = 1'b0;

`ifdef TIMER_PRESCALE_EN
      if (!en_q[i] || load[i] || tick[i])
        pcnt_d[i] = '0;
      else
        pcnt_d[i] = pcnt_q[i] + 8'd1;
`endif
    end
  end

  // Channel state registers with asynchronous clear
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      en_q   <= '0;
      im_q   <= '0;
      pend_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= '0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
`ifdef TIMER_PRESCALE_EN
        psc_q[i]    <= '0;
        pcnt_q[i]   <= '0;
`endif
      end
    end else begin
      en_q   <= en_d;
      im_q   <= im_d;
      pend_q <= pend_d;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
`ifdef TIMER_PRESCALE_EN
        psc_q[i]    <= psc_d[i];
        pcnt_q[i]   <= pcnt_d[i];
`endif
      end
    end
  end

  // Combinational read mux; unimplemented channels and bits read as zero
  always_comb begin
    DAT_O = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ADD_I[7:4] == 4'(i)) begin
        case (ADD_I[3:2])
          REG_CTRL: begin
            DAT_O[0]   = en_q[i];
            DAT_O[2:1] = mode_q[i];
            DAT_O[3]   = im_q[i];
`ifdef TIMER_PRESCALE_EN
            DAT_O[15:8] = psc_q[i];
`endif
          end
          REG_PRESET: DAT_O[CNT_W-1:0] = preset_q[i];
          REG_COUNT:  DAT_O[CNT_W-1:0] = count_q[i];
          default:    DAT_O[0]         = pend_q[i];
        endcase
      end
    end
  end

  // Interrupt outputs follow the registered pending/mask state
  always_comb begin
    IRQ_V = pend_q & im_q;
    IRQ   = |IRQ_V;
  end

endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: scoreboard bench for timer_array (N_CH=4, CNT_W=32).
// Expected values are queued as stimulus is applied and compared when the
// corresponding register or interrupt output is sampled.
`timescale 1ns/1ps
module tb_timer_array;

  logic        CLK_I;
  logic        RST_I;
  logic [7:2]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [3:0]  IRQ_V;
  logic        IRQ;

  timer_array #(.N_CH(4), .CNT_W(32)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .ADD_I (ADD_I),
    .WE_I  (WE_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .IRQ_V (IRQ_V),
    .IRQ   (IRQ)
  );

  initial CLK_I = 1'b0;
  always #50 CLK_I = ~CLK_I;

  localparam int K_REG  = 0;
  localparam int K_IRQV = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    string       tag;
    int          kind;
    logic [5:0]  addr;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic exp_reg(input string tag, input int ch, input int r, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag; it.kind = K_REG; it.exp = exp;
    it.addr = {4'(ch), 2'(r)};
    sb.push_back(it);
  endtask

  task automatic exp_irq(input string tag, input logic [3:0] v, input logic any);
    sb_item_t it;
    it.addr = '0;
    it.tag = {tag, "_irqv"}; it.kind = K_IRQV; it.exp = {28'd0, v};
    sb.push_back(it);
    it.tag = {tag, "_irq"};  it.kind = K_IRQ;  it.exp = {31'd0, any};
    sb.push_back(it);
  endtask

  // Pop every queued expectation and compare against the live outputs
  task automatic drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_REG: begin
          ADD_I = it.addr;
          #1;
          check_eq(it.tag, DAT_O, it.exp);
        end
        K_IRQV: begin
          #1;
          check_eq(it.tag, {28'd0, IRQ_V}, it.exp);
        end
        default: begin
          #1;
          check_eq(it.tag, {31'd0, IRQ}, it.exp);
        end
      endcase
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    ADD_I = {4'(ch), 2'(r)};
    DAT_I = d;
    WE_I  = 1'b1;
    @(posedge CLK_I);
    #1;
    WE_I  = 1'b0;
    DAT_I = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  initial begin
    RST_I = 1'b1;
    WE_I  = 1'b0;
    ADD_I = '0;
    DAT_I = '0;
    #20;
    exp_reg("rst_ctrl0", 0, 0, 32'h0);
    exp_reg("rst_cnt2", 2, 2, 32'h0);
    exp_reg("rst_stat3", 3, 3, 32'h0);
    exp_irq("rst", 4'h0, 1'b0);
    drain();
    RST_I = 1'b0;
    step(1);

    // One-shot on ch0: PRESET=5, CTRL=EN|IM
    wr(0, 1, 32'd5);
    wr(0, 0, 32'h9);
    exp_reg("os_load", 0, 2, 32'd5);
    drain();
    for (int j = 1; j <= 5; j++) begin
      step(1);
      exp_reg($sformatf("os_cnt%0d", j), 0, 2, 32'(5 - j));
      exp_irq($sformatf("os_pre%0d", j), 4'h0, 1'b0);
      drain();
    end
    step(1);
    exp_reg("os_stat", 0, 3, 32'h1);
    exp_reg("os_ctrl", 0, 0, 32'h8);
    exp_reg("os_cnt", 0, 2, 32'h0);
    exp_irq("os_exp", 4'h1, 1'b1);
    drain();
    wr(0, 3, 32'h1);
    exp_reg("os_clr", 0, 3, 32'h0);
    exp_irq("os_clr", 4'h0, 1'b0);
    drain();

    // Auto-reload on ch2: PRESET=3 -> pending every 4 edges
    wr(2, 1, 32'd3);
    wr(2, 0, 32'hB);
    step(3);
    exp_reg("rl_pre", 2, 3, 32'h0);
    exp_reg("rl_cnt0", 2, 2, 32'h0);
    drain();
    step(1);
    exp_reg("rl_p1", 2, 3, 32'h1);
    exp_reg("rl_reload", 2, 2, 32'd3);
    exp_irq("rl_p1", 4'h4, 1'b1);
    drain();
    wr(2, 3, 32'h1);
    exp_reg("rl_clr", 2, 3, 32'h0);
    exp_reg("rl_cnt2", 2, 2, 32'd2);
    drain();
    step(2);
    wr(2, 3, 32'h1);
    exp_reg("rl_clr_on_exp", 2, 3, 32'h1);
    exp_reg("rl_reload2", 2, 2, 32'd3);
    drain();
    wr(2, 0, 32'h0);
    wr(2, 3, 32'h1);
    exp_irq("rl_off", 4'h0, 1'b0);
    drain();

    // Masked pending on ch1: PRESET=2, IM=0
    wr(1, 1, 32'd2);
    wr(1, 0, 32'h1);
    step(3);
    exp_reg("im_stat", 1, 3, 32'h1);
    exp_irq("im_masked", 4'h0, 1'b0);
    drain();
    wr(1, 0, 32'h8);
    exp_irq("im_unmask", 4'h2, 1'b1);
    drain();
    wr(1, 3, 32'h0);
    exp_reg("im_w0", 1, 3, 32'h1);
    exp_irq("im_w0", 4'h2, 1'b1);
    drain();
    wr(1, 3, 32'h1);
    exp_irq("im_w1", 4'h0, 1'b0);
    drain();

    // Reserved mode 10 on ch1 holds the loaded count
    wr(1, 1, 32'd4);
    wr(1, 0, 32'h5);
    step(3);
    exp_reg("hold_cnt", 1, 2, 32'd4);
    exp_reg("hold_stat", 1, 3, 32'h0);
    drain();
    wr(1, 0, 32'h0);

    // Out-of-range channel and read-only COUNT
    wr(5, 1, 32'd7);
    wr(5, 0, 32'h9);
    exp_reg("oor_ctrl", 5, 0, 32'h0);
    exp_reg("oor_pre", 5, 1, 32'h0);
    exp_reg("oor_ch1", 1, 0, 32'h0);
    drain();
    wr(0, 2, 32'h1234);
    exp_reg("ro_cnt", 0, 2, 32'h0);
    exp_reg("ro_pre", 0, 1, 32'd5);
    drain();

    // Asynchronous reset mid-count on ch3 while ch0 interrupts
    wr(3, 1, 32'd100);
    wr(3, 0, 32'h9);
    wr(0, 1, 32'd0);
    wr(0, 0, 32'h9);
    step(1);
    exp_reg("mr_cnt3", 3, 2, 32'd97);
    exp_irq("mr_pre", 4'h1, 1'b1);
    drain();
    #2;
    RST_I = 1'b1;
    exp_irq("mr_async", 4'h0, 1'b0);
    drain();
    @(negedge CLK_I);
    RST_I = 1'b0;
    step(3);
    exp_reg("mr_cnt3_after", 3, 2, 32'h0);
    exp_reg("mr_ctrl3", 3, 0, 32'h0);
    exp_reg("mr_pre3", 3, 1, 32'h0);
    exp_reg("mr_stat0", 0, 3, 32'h0);
    drain();

    // Upper CTRL bits and the optional prescaler
`ifdef TIMER_PRESCALE_EN
    wr(0, 0, 32'hFFFF_FF08);
    exp_reg("ctrl_hi", 0, 0, 32'h0000_FF08);
    drain();
    wr(0, 0, 32'h0);
    wr(0, 1, 32'd1);
    wr(0, 0, 32'h209);
    step(5);
    exp_reg("psc_pre", 0, 3, 32'h0);
    drain();
    step(1);
    exp_reg("psc_exp", 0, 3, 32'h1);
    exp_reg("psc_ctrl", 0, 0, 32'h208);
    drain();
`else
    wr(0, 0, 32'hFFFF_FF08);
    exp_reg("ctrl_hi", 0, 0, 32'h0000_0008);
    drain();
    wr(0, 1, 32'd1);
    wr(0, 0, 32'h209);
    exp_reg("nopsc_ctrl", 0, 0, 32'h9);
    drain();
    step(1);
    exp_reg("nopsc_pre", 0, 3, 32'h0);
    drain();
    step(1);
    exp_reg("nopsc_exp", 0, 3, 32'h1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
